// File: rtl/avalon_pipelined_master_pkg.sv
// Shared types for the pipelined Avalon-MM master: command payload and sizing helpers.
package avalon_pipelined_master_pkg;

    localparam int unsigned CMD_ADDR_W = 32;
    localparam int unsigned CMD_DATA_W = 32;
    localparam int unsigned CMD_BE_W   = CMD_DATA_W / 8;

    typedef struct packed {
        logic [CMD_ADDR_W-1:0] addr;
        logic [CMD_BE_W-1:0]   be;
        logic [CMD_DATA_W-1:0] wdata;
        logic                  is_write;
    } avalon_cmd_t;

    // Pointer width that still works for a single-entry FIFO.
    function automatic int unsigned ptr_width(input int unsigned depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/avalon_cmd_fifo.sv
// Synchronous command FIFO with registered full/empty; any depth >= 1.
module avalon_cmd_fifo
    import avalon_pipelined_master_pkg::*;
#(
    parameter int unsigned DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        push_i,
    input  logic        pop_i,
    input  avalon_cmd_t din_i,
    output logic        full_o,
    output logic        empty_o,
    output avalon_cmd_t head_o
);

    localparam int unsigned PTR_W = ptr_width(DEPTH);
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             full_q, full_d;
    logic             empty_q, empty_d;
    logic             push_ok, pop_ok;
    avalon_cmd_t      mem_q [DEPTH];

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    assign push_ok = push_i & ~full_q;
    assign pop_ok  = pop_i & ~empty_q;

    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (push_ok) wr_ptr_d = ptr_inc(wr_ptr_q);
        if (pop_ok)  rd_ptr_d = ptr_inc(rd_ptr_q);
        case ({push_ok, pop_ok})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
        full_d  = (count_d == CNT_W'(DEPTH));
        empty_d = (count_d == '0);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
            full_q   <= 1'b0;
            empty_q  <= 1'b1;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
            full_q   <= full_d;
            empty_q  <= empty_d;
        end
    end

    // Storage is not reset: entries are only read once written.
    always_ff @(posedge clk) begin
        if (push_ok) mem_q[wr_ptr_q] <= din_i;
    end

    assign head_o  = mem_q[rd_ptr_q];
    assign full_o  = full_q;
    assign empty_o = empty_q;

endmodule

// File: rtl/avalon_pipelined_master.sv
// Pipelined Avalon-MM master: command FIFO, bus command stage, read credit counter, response register.
module avalon_pipelined_master
    import avalon_pipelined_master_pkg::*;
#(
    parameter int unsigned ADDR_W          = CMD_ADDR_W,
    parameter int unsigned DATA_W          = CMD_DATA_W,
    parameter int unsigned CMD_DEPTH       = 2,
    parameter int unsigned MAX_OUTSTANDING = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                req_valid,
    output logic                req_ready,
    input  logic                req_re,
    input  logic                req_we,
    input  logic [ADDR_W-1:0]   req_addr,
    input  logic [DATA_W/8-1:0] req_be,
    input  logic [DATA_W-1:0]   req_wdata,
    output logic                rsp_valid,
    output logic [DATA_W-1:0]   rsp_data,
    output logic                busy,
    output logic                protocol_error,
    output logic [ADDR_W-1:0]   avm_address,
    output logic [DATA_W/8-1:0] avm_byteenable,
    output logic [DATA_W-1:0]   avm_writedata,
    output logic                avm_read,
    output logic                avm_write,
    input  logic                avm_waitrequest,
    input  logic [DATA_W-1:0]   avm_readdata,
    input  logic                avm_readdatavalid
);

    localparam int unsigned BE_W  = DATA_W / 8;
    localparam int unsigned CNT_W = $clog2(MAX_OUTSTANDING + 1);
    localparam int unsigned IFL_W = CNT_W + 1;

    avalon_cmd_t       req_cmd, fifo_head, src_cmd;
    logic              fifo_full, fifo_empty, fifo_push, fifo_pop;
    logic              req_fire, cmd_valid, cmd_done, stage_free;
    logic              src_valid, read_ok, load;
    logic [IFL_W-1:0]  in_flight;
    logic              cnt_inc, spurious;

    logic              avm_read_q, avm_read_d;
    logic              avm_write_q, avm_write_d;
    logic [ADDR_W-1:0] avm_address_q, avm_address_d;
    logic [BE_W-1:0]   avm_byteenable_q, avm_byteenable_d;
    logic [DATA_W-1:0] avm_writedata_q, avm_writedata_d;
    logic [CNT_W-1:0]  out_cnt_q, out_cnt_d;
    logic              rsp_valid_q, rsp_valid_d;
    logic [DATA_W-1:0] rsp_data_q, rsp_data_d;
    logic              perr_q, perr_d;

    always_comb begin
        req_cmd          = '0;
        req_cmd.addr     = CMD_ADDR_W'(req_addr);
        req_cmd.be       = CMD_BE_W'(req_be);
        req_cmd.wdata    = CMD_DATA_W'(req_wdata);
        req_cmd.is_write = req_we;
    end

    avalon_cmd_fifo #(
        .DEPTH (CMD_DEPTH)
    ) u_cmd_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (fifo_push),
        .pop_i   (fifo_pop),
        .din_i   (req_cmd),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .head_o  (fifo_head)
    );

    assign req_ready  = ~fifo_full;
    assign req_fire   = req_valid & ~fifo_full & (req_re | req_we);
    assign cmd_valid  = avm_read_q | avm_write_q;
    assign cmd_done   = cmd_valid & ~avm_waitrequest;
    assign stage_free = ~cmd_valid | ~avm_waitrequest;

    // An empty FIFO lets an incoming request bypass straight into the command stage.
    assign src_cmd   = fifo_empty ? req_cmd : fifo_head;
    assign src_valid = ~fifo_empty | req_fire;

    // A read returning this cycle frees its credit for the read being loaded.
    assign in_flight = IFL_W'(out_cnt_q) + IFL_W'(avm_read_q)
                     - IFL_W'(avm_readdatavalid && (out_cnt_q != '0));
    assign read_ok   = in_flight < IFL_W'(MAX_OUTSTANDING);
    assign load      = stage_free & src_valid & (src_cmd.is_write | read_ok);
    assign fifo_pop  = load & ~fifo_empty;
    assign fifo_push = req_fire & ~(load & fifo_empty);

    assign cnt_inc  = avm_read_q & ~avm_waitrequest;
    assign spurious = avm_readdatavalid & ~cnt_inc & (out_cnt_q == '0);

    always_comb begin
        avm_read_d       = avm_read_q;
        avm_write_d      = avm_write_q;
        avm_address_d    = avm_address_q;
        avm_byteenable_d = avm_byteenable_q;
        avm_writedata_d  = avm_writedata_q;
        if (load) begin
            avm_read_d       = ~src_cmd.is_write;
            avm_write_d      = src_cmd.is_write;
            avm_address_d    = ADDR_W'(src_cmd.addr);
            avm_byteenable_d = BE_W'(src_cmd.be);
            avm_writedata_d  = DATA_W'(src_cmd.wdata);
        end else if (cmd_done) begin
            avm_read_d  = 1'b0;
            avm_write_d = 1'b0;
        end
    end

    always_comb begin
        out_cnt_d = out_cnt_q;
        case ({cnt_inc, avm_readdatavalid})
            2'b10:   out_cnt_d = out_cnt_q + CNT_W'(1);
            2'b01:   out_cnt_d = (out_cnt_q != '0) ? out_cnt_q - CNT_W'(1) : out_cnt_q;
            default: out_cnt_d = out_cnt_q;
        endcase
        perr_d      = perr_q | spurious;
        rsp_valid_d = avm_readdatavalid;
        rsp_data_d  = avm_readdatavalid ? avm_readdata : '0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            avm_read_q       <= 1'b0;
            avm_write_q      <= 1'b0;
            avm_address_q    <= '0;
            avm_byteenable_q <= '0;
            avm_writedata_q  <= '0;
            out_cnt_q        <= '0;
            rsp_valid_q      <= 1'b0;
            rsp_data_q       <= '0;
            perr_q           <= 1'b0;
        end else begin
            avm_read_q       <= avm_read_d;
            avm_write_q      <= avm_write_d;
            avm_address_q    <= avm_address_d;
            avm_byteenable_q <= avm_byteenable_d;
            avm_writedata_q  <= avm_writedata_d;
            out_cnt_q        <= out_cnt_d;
            rsp_valid_q      <= rsp_valid_d;
            rsp_data_q       <= rsp_data_d;
            perr_q           <= perr_d;
        end
    end

    assign busy           = ~fifo_empty | cmd_valid | (out_cnt_q != '0);
    assign avm_read       = avm_read_q;
    assign avm_write      = avm_write_q;
    assign avm_address    = avm_address_q;
    assign avm_byteenable = avm_byteenable_q;
    assign avm_writedata  = avm_writedata_q;
    assign rsp_valid      = rsp_valid_q;
    assign rsp_data       = rsp_data_q;
    assign protocol_error = perr_q;

endmodule

// File: doc/avalon_pipelined_master.md
Name: avalon_pipelined_master

Overview:
- Parametrised Avalon-MM master for the memory sub-unit path: accepts load/store requests and drives a pipelined Avalon-MM bus with `readdatavalid`.
- Supports up to `MAX_OUTSTANDING` reads in flight, so a new command can issue while earlier read data is still pending.
- Buffers up to `CMD_DEPTH` commands and returns read data in order.
- Sits between the load-store unit and an Avalon interconnect.

Parameters:
- ADDR_W, 32, address width
- DATA_W, 32, data width; must be a multiple of 8
- CMD_DEPTH, 2, command FIFO entries; must be ≥1
- MAX_OUTSTANDING, 4, maximum reads accepted by the slave but not yet returned; must be ≥1

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- req_valid  in  1  request present
- req_ready  out  1  request accepted when req_valid & req_ready
- req_re  in  1  read request
- req_we  in  1  write request (exactly one of req_re/req_we set with req_valid)
- req_addr  in  ADDR_W  byte address
- req_be  in  DATA_W/8  byte enables
- req_wdata  in  DATA_W  write data
- rsp_valid  out  1  read data valid, one-cycle pulse
- rsp_data  out  DATA_W  read data
- busy  out  1  FIFO non-empty, bus command active, or reads outstanding
- protocol_error  out  1  sticky: readdatavalid seen with no read outstanding
- avm_address  out  ADDR_W
- avm_byteenable  out  DATA_W/8
- avm_writedata  out  DATA_W
- avm_read  out  1
- avm_write  out  1
- avm_waitrequest  in  1
- avm_readdata  in  DATA_W
- avm_readdatavalid  in  1

Behaviour:
- Reset values:
  - avm_read=0, avm_write=0, rsp_valid=0, rsp_data=0, protocol_error=0.
  - FIFO empty, outstanding count=0, req_ready=1.
  - Address, byteenable and writedata are don't-care until the first command is loaded.
- Request side:
  - req_ready = FIFO not full.
  - An accepted request is written into the FIFO in the same cycle.
  - FIFO entry holds {addr, be, wdata, is_write}.
- Command stage (bus register):
  - Valid when avm_read|avm_write.
  - Loads the FIFO head when the stage is empty, or when the current command completes this cycle (avm_waitrequest=0).
  - A read head additionally requires that issuing it keeps reads in flight ≤ MAX_OUTSTANDING. Count reads in flight as the outstanding count plus any read currently held in the command stage.
  - Back-to-back issue: with waitrequest low on every cycle, a new command is presented every cycle. There is no idle cycle between commands.
  - While avm_waitrequest=1, all avm_* outputs are held stable.
  - Minimum latency: request accepted in cycle N, avm_read/avm_write asserted in cycle N+1.
- Outstanding counter, width clog2(MAX_OUTSTANDING+1):
  - +1 when avm_read & ~avm_waitrequest.
  - −1 when avm_readdatavalid.
  - Both in the same cycle: unchanged.
  - Never exceeds MAX_OUTSTANDING.
  - If readdatavalid arrives with count=0 and no accept this cycle: count stays 0 and protocol_error sets.
- Writes complete on acceptance (no write response) and do not touch the counter.
- Read return:
  - rsp_valid <= avm_readdatavalid.
  - rsp_data <= avm_readdata when readdatavalid, else 0.
  - Latency is one cycle after readdatavalid; returns are in issue order.
  - The requester always accepts responses; there is no backpressure on rsp.
- Ordering: read-after-write to the same address is guaranteed by in-order bus issue. The block does no further hazard checking.
- Simultaneous events:
  - FIFO push and pop in the same cycle while full: not permitted, because req_ready is computed from the registered full flag.
  - Push and pop when not full: occupancy unchanged.
- Reset mid-operation:
  - All state cleared on the next edge: FIFO entries dropped, command stage cleared, counter cleared.
  - Late readdatavalid after reset sets protocol_error. This is legal and expected; software clears it only by reset.
- busy is combinational from registered state.

Decomposition:
- Shared package entries:
  - avalon_cmd_t struct {addr, be, wdata, is_write}, widths from the parameters (parametrised struct via the package localparam convention).
- Sub-module avalon_cmd_fifo:
  - Synchronous FIFO of avalon_cmd_t, depth CMD_DEPTH.
  - Ports: push, pop, full, empty, head; registered full/empty; pointer wrap at CMD_DEPTH, non-power-of-two depths supported.
- Top level contains the command stage, the outstanding counter and the response register.

Test Plan:
- Single read: addr=0x100, slave waitrequest=0, readdatavalid 3 cycles after accept with 0xDEADBEEF -> avm_read high exactly 1 cycle; rsp_valid one cycle after readdatavalid, rsp_data=0xDEADBEEF; busy low afterwards.
- Waitrequest stall: write addr=0x40, be=0x3, data=0x1234, waitrequest high 4 cycles -> address/byteenable/writedata/write stable all 4 cycles; write drops the cycle after waitrequest falls; counter stays 0.
- Pipelined reads: 6 reads back-to-back, MAX_OUTSTANDING=4, slave latency 10 -> exactly 4 accepted before the first readdatavalid; 5th issues the cycle readdatavalid #1 arrives; 6 responses returned in order.
- FIFO full: CMD_DEPTH=2, waitrequest held high, 4 requests offered -> req_ready drops after the FIFO fills (one command held on the bus plus 2 queued); no request lost; all 3 issue once waitrequest falls.
- Simultaneous accept/return: read accepted in the same cycle as readdatavalid at count=2 -> count stays 2.
- Reset mid-read plus spurious return: rst while 2 reads outstanding, then readdatavalid -> avm_read=0, count=0, protocol_error=1, rsp_valid pulses once with the returned data.
